// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU control FSM; optional macro SEQ_INSTR_COUNT_EN enables the retired-instruction counter
module cpu_sequencer #(
    parameter int PC_WIDTH   = 5,
    parameter int IO_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [31:0]         instr,
    input  logic                alu_is_branch,
    input  logic                alu_is_jal,
    input  logic [1:0]          alu_load_write,
    input  logic [1:0]          alu_in_out,
    input  logic [4:0]          alu_wb_addr,
    input  logic                io_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ir,
    output logic                reg_we,
    output logic [4:0]          reg_waddr,
    output logic [1:0]          reg_wsel,
    output logic                mem_re,
    output logic                mem_we,
    output logic                io_req,
    output logic                io_dir,
    output logic                halted,
    output logic                io_error,
    output logic [15:0]         instr_count
);

    // wait counter only has to reach IO_TIMEOUT-1
    localparam int TW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(IO_TIMEOUT - 1);

    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_RAM = 2'd1;
    localparam logic [1:0] WSEL_PC1 = 2'd2;
    localparam logic [1:0] WSEL_IO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_IO_WAIT,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                reg_we_q, reg_we_d;
    logic [4:0]          reg_waddr_q, reg_waddr_d;
    logic [1:0]          reg_wsel_q, reg_wsel_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic                io_req_q, io_req_d;
    logic                io_dir_q, io_dir_d;
    logic                io_error_q, io_error_d;
    logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
    // ALU results captured in EXEC so later ALU glitches cannot disturb retirement
    logic                br_q, br_d;
    logic                load_q, load_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic                retire;
    logic [PC_WIDTH-1:0] br_target;

    assign br_target = PC_WIDTH'(wb_addr_q);

    // ALU-result writers: R-type except jr and nop, plus the immediate ALU ops
    function automatic logic writes_alu_result(input logic [31:0] insn);
        logic [5:0] op;
        op = insn[31:26];
        case (op)
            OP_RTYPE: return (insn != 32'd0) && (insn[5:0] != FN_JR);
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // next-state, strobe and pc logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wsel_d  = reg_wsel_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        io_req_d    = io_req_q;
        io_dir_d    = io_dir_q;
        io_error_d  = io_error_q;
        wait_cnt_d  = wait_cnt_q;
        br_d        = br_q;
        load_d      = load_q;
        wb_addr_d   = wb_addr_q;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                br_d      = alu_is_branch | alu_is_jal;
                load_d    = alu_load_write[1];
                wb_addr_d = alu_wb_addr;
                if (ir_q == HALT_INSN) begin
                    state_d = S_HALT;
                end else if (alu_load_write != 2'b00) begin
                    state_d  = S_MEM;
                    mem_re_d = alu_load_write[1];
                    mem_we_d = ~alu_load_write[1];
                end else if (alu_in_out != 2'b00) begin
                    state_d    = S_IO_WAIT;
                    io_req_d   = 1'b1;
                    io_dir_d   = alu_in_out[1];
                    wait_cnt_d = '0;
                end else begin
                    state_d = S_WB;
                    if (alu_is_jal) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = 5'd31;
                        reg_wsel_d  = WSEL_PC1;
                    end else if (writes_alu_result(ir_q)) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = alu_wb_addr;
                        reg_wsel_d  = WSEL_ALU;
                    end
                end
            end
            S_MEM: begin
                if (load_q) begin
                    state_d     = S_WB;
                    reg_we_d    = 1'b1;
                    reg_waddr_d = ir_q[20:16];
                    reg_wsel_d  = WSEL_RAM;
                end else begin
                    retire = 1'b1;
                end
            end
            S_IO_WAIT: begin
                if (io_ack) begin
                    io_req_d = 1'b0;
                    io_dir_d = 1'b0;
                    if (io_dir_q) begin
                        state_d     = S_WB;
                        reg_we_d    = 1'b1;
                        reg_waddr_d = ir_q[4:0];
                        reg_wsel_d  = WSEL_IO;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // abandoned I/O retires as a nop
                    io_req_d   = 1'b0;
                    io_dir_d   = 1'b0;
                    io_error_d = 1'b1;
                    retire     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            pc_d    = br_q ? br_target : pc_q + 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wsel_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            io_req_q    <= 1'b0;
            io_dir_q    <= 1'b0;
            io_error_q  <= 1'b0;
            wait_cnt_q  <= '0;
            br_q        <= 1'b0;
            load_q      <= 1'b0;
            wb_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wsel_q  <= reg_wsel_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            io_req_q    <= io_req_d;
            io_dir_q    <= io_dir_d;
            io_error_q  <= io_error_d;
            wait_cnt_q  <= wait_cnt_d;
            br_q        <= br_d;
            load_q      <= load_d;
            wb_addr_q   <= wb_addr_d;
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] instr_count_q, instr_count_d;

    // retired-instruction counter, wraps naturally at 16'hFFFF
    always_comb begin
        instr_count_d = instr_count_q + 16'(retire);
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = 16'd0;
`endif

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wsel  = reg_wsel_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign io_req    = io_req_q;
    assign io_dir    = io_dir_q;
    assign io_error  = io_error_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer (honours SEQ_INSTR_COUNT_EN)
module tb_cpu_sequencer;

    localparam int PW = 5;

    logic          clk;
    logic          rst;
    logic          run;
    logic [31:0]   instr;
    logic          alu_is_branch;
    logic          alu_is_jal;
    logic [1:0]    alu_load_write;
    logic [1:0]    alu_in_out;
    logic [4:0]    alu_wb_addr;
    logic          io_ack;
    logic [PW-1:0] pc;
    logic [31:0]   ir;
    logic          reg_we;
    logic [4:0]    reg_waddr;
    logic [1:0]    reg_wsel;
    logic          mem_re;
    logic          mem_we;
    logic          io_req;
    logic          io_dir;
    logic          halted;
    logic          io_error;
    logic [15:0]   instr_count;

    logic [31:0]   rom [0:31];
    int            errors = 0;
    int            checks = 0;

    localparam logic [31:0] I_ADDI = 32'h2001_0005;
    localparam logic [31:0] I_SW   = 32'hAC02_0000;
    localparam logic [31:0] I_BEQ  = 32'h1000_0009;
    localparam logic [31:0] I_JAL  = 32'h0C00_0014;
    localparam logic [31:0] I_LW   = 32'h8C02_0000;
    localparam logic [31:0] I_IN   = 32'h7C00_0003;
    localparam logic [31:0] I_OUT  = 32'h7C00_0001;
    localparam logic [31:0] I_J    = 32'h0800_001F;

    assign instr = rom[pc];

    cpu_sequencer #(
        .PC_WIDTH   (PW),
        .IO_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .instr          (instr),
        .alu_is_branch  (alu_is_branch),
        .alu_is_jal     (alu_is_jal),
        .alu_load_write (alu_load_write),
        .alu_in_out     (alu_in_out),
        .alu_wb_addr    (alu_wb_addr),
        .io_ack         (io_ack),
        .pc             (pc),
        .ir             (ir),
        .reg_we         (reg_we),
        .reg_waddr      (reg_waddr),
        .reg_wsel       (reg_wsel),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .io_req         (io_req),
        .io_dir         (io_dir),
        .halted         (halted),
        .io_error       (io_error),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic br, input logic jal, input logic [1:0] lw,
                           input logic [1:0] io, input logic [4:0] wb);
        alu_is_branch  = br;
        alu_is_jal     = jal;
        alu_load_write = lw;
        alu_in_out     = io;
        alu_wb_addr    = wb;
    endtask

    function automatic logic [31:0] cnt(input int n);
`ifdef SEQ_INSTR_COUNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'd0;
        rom[0]  = I_ADDI;
        rom[1]  = I_SW;
        rom[2]  = I_BEQ;
        rom[9]  = I_JAL;
        rom[20] = I_LW;
        rom[21] = I_IN;
        rom[22] = I_OUT;
        rom[23] = I_J;

        rst = 1'b1;
        run = 1'b0;
        io_ack = 1'b0;
        set_alu(1'b0, 1'b0, 2'b00, 2'b00, 5'd0);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", ir, 0);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_io_req", 32'(io_req), 0);
        chk("rst_io_dir", 32'(io_dir), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_io_error", 32'(io_error), 0);
        chk("rst_count", 32'(instr_count), 0);

        // addi at pc 0, stray io_ack must be ignored
        run = 1'b1;
        io_ack = 1'b1;
        set_alu(1'b0, 1'b0, 2'b00, 2'b00, 5'd1);
        tick();
        tick();
        chk("addi_ir", ir, I_ADDI);
        tick();
        chk("addi_exec_no_we", 32'(reg_we), 0);
        tick();
        chk("addi_we", 32'(reg_we), 1);
        chk("addi_waddr", 32'(reg_waddr), 1);
        chk("addi_wsel", 32'(reg_wsel), 0);
        chk("addi_pc_hold", 32'(pc), 0);
        chk("addi_no_io_req", 32'(io_req), 0);
        io_ack = 1'b0;
        tick();
        chk("addi_pc", 32'(pc), 1);
        chk("addi_we_drop", 32'(reg_we), 0);
        chk("addi_count", 32'(instr_count), cnt(1));

        // sw at pc 1: 4 cycles
        set_alu(1'b0, 1'b0, 2'b01, 2'b00, 5'd0);
        tick();
        tick();
        tick();
        chk("sw_mem_we", 32'(mem_we), 1);
        chk("sw_mem_re", 32'(mem_re), 0);
        chk("sw_reg_we", 32'(reg_we), 0);
        tick();
        chk("sw_mem_we_drop", 32'(mem_we), 0);
        chk("sw_pc", 32'(pc), 2);
        chk("sw_count", 32'(instr_count), cnt(2));

        // beq taken to 9; ALU glitch after EXEC ignored
        set_alu(1'b1, 1'b0, 2'b00, 2'b00, 5'd9);
        tick();
        tick();
        tick();
        chk("beq_no_we", 32'(reg_we), 0);
        set_alu(1'b0, 1'b0, 2'b00, 2'b00, 5'd0);
        tick();
        chk("beq_pc", 32'(pc), 9);

        // jal to 20
        set_alu(1'b0, 1'b1, 2'b00, 2'b00, 5'd20);
        tick();
        tick();
        tick();
        chk("jal_we", 32'(reg_we), 1);
        chk("jal_waddr", 32'(reg_waddr), 31);
        chk("jal_wsel", 32'(reg_wsel), 2);
        tick();
        chk("jal_pc", 32'(pc), 20);
        chk("jal_count", 32'(instr_count), cnt(4));

        // lw at pc 20: 5 cycles
        set_alu(1'b0, 1'b0, 2'b10, 2'b00, 5'd0);
        tick();
        tick();
        tick();
        chk("lw_mem_re", 32'(mem_re), 1);
        chk("lw_mem_we", 32'(mem_we), 0);
        chk("lw_no_we_yet", 32'(reg_we), 0);
        tick();
        chk("lw_mem_re_drop", 32'(mem_re), 0);
        chk("lw_we", 32'(reg_we), 1);
        chk("lw_wsel", 32'(reg_wsel), 1);
        chk("lw_waddr", 32'(reg_waddr), 2);
        chk("lw_pc_hold", 32'(pc), 20);
        tick();
        chk("lw_pc", 32'(pc), 21);

        // in at pc 21, ack in the third wait cycle
        set_alu(1'b0, 1'b0, 2'b00, 2'b10, 5'd0);
        tick();
        tick();
        tick();
        chk("in_req1", 32'(io_req), 1);
        chk("in_dir", 32'(io_dir), 1);
        tick();
        chk("in_req2", 32'(io_req), 1);
        tick();
        chk("in_req3", 32'(io_req), 1);
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        chk("in_req_drop", 32'(io_req), 0);
        chk("in_we", 32'(reg_we), 1);
        chk("in_wsel", 32'(reg_wsel), 3);
        chk("in_waddr", 32'(reg_waddr), 3);
        tick();
        chk("in_pc", 32'(pc), 22);
        chk("in_count", 32'(instr_count), cnt(6));

        // out at pc 22, never acked: times out after 4 cycles
        set_alu(1'b0, 1'b0, 2'b00, 2'b01, 5'd0);
        tick();
        tick();
        tick();
        chk("out_req1", 32'(io_req), 1);
        chk("out_dir", 32'(io_dir), 0);
        tick();
        tick();
        tick();
        chk("out_req4", 32'(io_req), 1);
        chk("out_no_err_yet", 32'(io_error), 0);
        chk("out_pc_hold", 32'(pc), 22);
        tick();
        chk("out_req_drop", 32'(io_req), 0);
        chk("out_io_error", 32'(io_error), 1);
        chk("out_no_we", 32'(reg_we), 0);
        chk("out_pc", 32'(pc), 23);
        chk("out_count", 32'(instr_count), cnt(7));

        // j to 31, then nop at 31 wraps to 0
        set_alu(1'b1, 1'b0, 2'b00, 2'b00, 5'd31);
        tick();
        tick();
        tick();
        chk("j_no_we", 32'(reg_we), 0);
        tick();
        chk("j_pc", 32'(pc), 31);
        set_alu(1'b0, 1'b0, 2'b00, 2'b00, 5'd0);
        tick();
        tick();
        tick();
        chk("nop_no_we", 32'(reg_we), 0);
        tick();
        chk("nop_pc_wrap", 32'(pc), 0);

        // run drops mid-instruction: completes, then parks in IDLE
        set_alu(1'b0, 1'b0, 2'b00, 2'b00, 5'd1);
        tick();
        run = 1'b0;
        tick();
        tick();
        chk("park_we", 32'(reg_we), 1);
        tick();
        chk("park_pc", 32'(pc), 1);
        chk("park_count", 32'(instr_count), cnt(10));
        tick();
        tick();
        chk("park_pc_hold", 32'(pc), 1);
        chk("park_ir_hold", ir, I_ADDI);
        chk("park_err_sticky", 32'(io_error), 1);

        // resume, reset during MEM of sw
        run = 1'b1;
        tick();
        tick();
        chk("sw2_ir", ir, I_SW);
        set_alu(1'b0, 1'b0, 2'b01, 2'b00, 5'd0);
        tick();
        tick();
        chk("sw2_mem_we", 32'(mem_we), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_mem_we", 32'(mem_we), 0);
        chk("mrst_pc", 32'(pc), 0);
        chk("mrst_ir", ir, 0);
        chk("mrst_io_error", 32'(io_error), 0);
        chk("mrst_count", 32'(instr_count), 0);

        // HALT has priority over ALU flags and is absorbing
        rom[0] = 32'hFFFF_FFFF;
        set_alu(1'b1, 1'b0, 2'b01, 2'b00, 5'd5);
        tick();
        tick();
        chk("halt_ir", ir, 32'hFFFF_FFFF);
        tick();
        chk("halt_not_yet", 32'(halted), 0);
        tick();
        chk("halt_set", 32'(halted), 1);
        chk("halt_no_mem_we", 32'(mem_we), 0);
        tick();
        tick();
        tick();
        chk("halt_held", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 0);
        chk("halt_count", 32'(instr_count), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_rst", 32'(halted), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
